// File: rtl/scheduler_pkg.sv
// rtl/scheduler_pkg.sv - shared types, default widths and popcount helpers for the rename free list
// Contents:
//   PHY_REG_NUM_DEF / DECODE_WIDTH_DEF / COMMIT_WIDTH_DEF  default sizes
//   PregIdx, FreeListPtr                                   register index / wrap-bit pointer types
//   popcount(v), prefix_count(v, idx)                      population count helpers
// Width macros DECODE_WIDTH and COMMIT_WIDTH default to 4 when not supplied.
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

package scheduler_pkg;

  localparam int PHY_REG_NUM_DEF  = 64;
  localparam int DECODE_WIDTH_DEF = `DECODE_WIDTH;
  localparam int COMMIT_WIDTH_DEF = `COMMIT_WIDTH;
  localparam int PW_DEF           = $clog2(PHY_REG_NUM_DEF);

  // Helpers operate on a fixed maximum vector width; callers zero-extend.
  localparam int MAX_VEC_W = 16;
  localparam int CNT_W     = $clog2(MAX_VEC_W + 1);

  typedef logic [PW_DEF-1:0]    PregIdx;
  typedef logic [PW_DEF:0]      FreeListPtr;
  typedef logic [MAX_VEC_W-1:0] ReqVec;
  typedef logic [CNT_W-1:0]     ReqCnt;

  function automatic ReqCnt popcount(input ReqVec v);
    ReqCnt c;
    c = '0;
    for (int i = 0; i < MAX_VEC_W; i++) c = c + ReqCnt'(v[i]);
    return c;
  endfunction

  // Number of set bits strictly below position idx: the compaction offset of slot idx.
  function automatic ReqCnt prefix_count(input ReqVec v, input int idx);
    ReqCnt c;
    c = '0;
    for (int i = 0; i < MAX_VEC_W; i++) begin
      if (i < idx) c = c + ReqCnt'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prefix_popcount.sv
// rtl/prefix_popcount.sv - per-slot prefix offsets and total count of a request vector
// Ports:
//   req_i    in   W        request bits
//   offs_o   out  W x CW   offs_o[i] = number of set bits in req_i[i-1:0]
//   total_o  out  CW       number of set bits in req_i
module prefix_popcount
  import scheduler_pkg::*;
#(
  parameter int W = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]         req_i,
  output logic [W-1:0][CW-1:0] offs_o,
  output logic [CW-1:0]        total_o
);

  ReqVec req_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[W-1:0] = req_i;
    total_o        = CW'(popcount(req_ext));
    for (int i = 0; i < W; i++) begin
      offs_o[i] = CW'(prefix_count(req_ext, i));
    end
  end

endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - circular-queue physical register free list feeding the rename table
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   alloc_valid_i   in   DECODE_WIDTH       per-slot destination request
//   alloc_ready_o   out  1                  free count >= DECODE_WIDTH
//   preg_o          out  DECODE_WIDTH x PW  allocated registers, compacted onto valid slots
//   commit_i        in   COMMIT_WIDTH       committing slot owns a destination
//   free_i          in   COMMIT_WIDTH       old register released
//   free_preg_i     in   COMMIT_WIDTH x PW  registers to release
//   restore_i       in   1                  flush: head rolls back to the committed head
//   free_cnt_o      out  PW+1               registers currently free
//   err_o           out  1                  sticky misuse flag (only with FREELIST_CHECK_EN)
// Optional feature macro: FREELIST_CHECK_EN
module free_list
  import scheduler_pkg::*;
#(
  parameter int PHY_REG_NUM  = PHY_REG_NUM_DEF,
  parameter int DECODE_WIDTH = DECODE_WIDTH_DEF,
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
  localparam int PW = $clog2(PHY_REG_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DECODE_WIDTH-1:0]           alloc_valid_i,
  output logic                              alloc_ready_o,
  output logic [DECODE_WIDTH-1:0][PW-1:0]   preg_o,
  input  logic [COMMIT_WIDTH-1:0]           commit_i,
  input  logic [COMMIT_WIDTH-1:0]           free_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]   free_preg_i,
  input  logic                              restore_i,
  output logic [PW:0]                       free_cnt_o
`ifdef FREELIST_CHECK_EN
  ,
  output logic                              err_o
`endif
);

  localparam int AW    = $clog2(DECODE_WIDTH + 1);
  localparam int FW    = $clog2(COMMIT_WIDTH + 1);
  localparam int PTR_W = PW + 1;

  logic [PW-1:0]  entry_q [PHY_REG_NUM];
  logic [PW:0]    head_q, head_d;
  logic [PW:0]    arch_head_q, arch_head_d;
  logic [PW:0]    tail_q, tail_d;
  logic [PW:0]    free_cnt_q, free_cnt_d;

  logic [DECODE_WIDTH-1:0][AW-1:0] a_offs;
  logic [AW-1:0]                   a_total;
  logic [COMMIT_WIDTH-1:0][FW-1:0] f_offs;
  logic [FW-1:0]                   f_total;
  logic [FW-1:0]                   c_total;
  ReqVec                           commit_ext;
  logic [COMMIT_WIDTH-1:0][PW-1:0] wr_idx;
  logic                            fire;

  prefix_popcount #(.W(DECODE_WIDTH)) u_alloc_pc (
    .req_i   (alloc_valid_i),
    .offs_o  (a_offs),
    .total_o (a_total)
  );

  prefix_popcount #(.W(COMMIT_WIDTH)) u_free_pc (
    .req_i   (free_i),
    .offs_o  (f_offs),
    .total_o (f_total)
  );

  // Commits only need the total, so the per-slot offsets are not built here.
  always_comb begin
    commit_ext                   = '0;
    commit_ext[COMMIT_WIDTH-1:0] = commit_i;
    c_total                      = FW'(popcount(commit_ext));
  end

  // Grant is all-or-nothing: a partial request still waits for a full group.
  assign alloc_ready_o = free_cnt_q >= PTR_W'(DECODE_WIDTH);
  assign fire          = alloc_ready_o & (|alloc_valid_i) & ~restore_i;
  assign free_cnt_o    = free_cnt_q;

  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      preg_o[i] = entry_q[head_q[PW-1:0] + PW'(a_offs[i])];
    end
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      wr_idx[j] = tail_q[PW-1:0] + PW'(f_offs[j]);
    end
  end

  always_comb begin
    arch_head_d = arch_head_q + PTR_W'(c_total);
    tail_d      = tail_q + PTR_W'(f_total);
    head_d      = head_q;
    // Restore takes the committed head including this cycle's commits.
    if (restore_i) begin
      head_d = arch_head_d;
    end else if (fire) begin
      head_d = head_q + PTR_W'(a_total);
    end
    free_cnt_d  = tail_d - head_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PHY_REG_NUM; k++) begin
        entry_q[k] <= PW'(k);
      end
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= PTR_W'(PHY_REG_NUM);
      free_cnt_q  <= PTR_W'(PHY_REG_NUM);
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (free_i[j]) entry_q[wr_idx[j]] <= free_preg_i[j];
      end
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      free_cnt_q  <= free_cnt_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  logic        err_q;
  logic        over_free;
  logic        commit_past;
  logic        alloc_under;
  logic [PW:0] in_flight;

  // One extra bit so free_cnt + frees cannot wrap before the compare.
  assign over_free   = ({1'b0, free_cnt_q} + (PTR_W + 1)'(f_total)) > (PTR_W + 1)'(PHY_REG_NUM);
  assign in_flight   = head_q - arch_head_q;
  assign commit_past = PTR_W'(c_total) > in_flight;
  assign alloc_under = fire & (free_cnt_q < PTR_W'(a_total));
  assign err_o       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (over_free | commit_past | alloc_under) begin
      err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!over_free)   else $error("free_list: free overflows queue");
      assert (!commit_past) else $error("free_list: commit passes allocation head");
      assert (!alloc_under) else $error("free_list: allocation exceeds free count");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for free_list with directed vectors
module tb_free_list;

  localparam int PW = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         alloc_valid_i;
  logic               alloc_ready_o;
  logic [3:0][PW-1:0] preg_o;
  logic [3:0]         commit_i;
  logic [3:0]         free_i;
  logic [3:0][PW-1:0] free_preg_i;
  logic               restore_i;
  logic [PW:0]        free_cnt_o;
`ifdef FREELIST_CHECK_EN
  logic               err_o;
`endif

  free_list #(.PHY_REG_NUM(64), .DECODE_WIDTH(4), .COMMIT_WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid_i (alloc_valid_i),
    .alloc_ready_o (alloc_ready_o),
    .preg_o        (preg_o),
    .commit_i      (commit_i),
    .free_i        (free_i),
    .free_preg_i   (free_preg_i),
    .restore_i     (restore_i),
    .free_cnt_o    (free_cnt_o)
`ifdef FREELIST_CHECK_EN
    ,
    .err_o         (err_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    sel;   // 0 free_cnt_o, 1 alloc_ready_o, 2 err_o
    int    val;
    string name;
  } st_exp_t;

  typedef struct {
    logic [3:0]         mask;
    logic [3:0][PW-1:0] p;
    string              name;
  } al_exp_t;

  st_exp_t exp_st_q[$];
  al_exp_t exp_al_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic done    = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_state(input int dly, input int sel, input int val, input string nm);
    st_exp_t e;
    e.cyc  = cyc + dly;
    e.sel  = sel;
    e.val  = val;
    e.name = nm;
    exp_st_q.push_back(e);
  endtask

  // Drive an allocation that is expected to fire and queue its expected registers.
  task automatic alloc(input logic [3:0] m, input int p0, input int p1, input int p2,
                       input int p3, input string nm);
    al_exp_t a;
    a.mask = m;
    a.p[0] = PW'(p0);
    a.p[1] = PW'(p1);
    a.p[2] = PW'(p2);
    a.p[3] = PW'(p3);
    a.name = nm;
    exp_al_q.push_back(a);
    alloc_valid_i = m;
  endtask

  task automatic clear_inputs();
    alloc_valid_i = '0;
    commit_i      = '0;
    free_i        = '0;
    free_preg_i   = '0;
    restore_i     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: pops alloc expectations on every DUT fire, state expectations by cycle.
  al_exp_t m_a;
  st_exp_t m_s;
  int      m_act;
  logic    done_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (alloc_ready_o && (|alloc_valid_i) && !restore_i) begin
        if (exp_al_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_alloc: got fire at cycle %0d, want none", cyc);
        end else begin
          m_a = exp_al_q.pop_front();
          for (int i = 0; i < 4; i++) begin
            if (m_a.mask[i]) begin
              n_tests++;
              if (preg_o[i] !== m_a.p[i]) begin
                n_fail++;
                $display("FAIL %s slot%0d: got %0d, want %0d", m_a.name, i, preg_o[i], m_a.p[i]);
              end
            end
          end
        end
      end
      while (exp_st_q.size() > 0 && exp_st_q[0].cyc <= cyc) begin
        m_s = exp_st_q.pop_front();
        n_tests++;
`ifdef FREELIST_CHECK_EN
        m_act = (m_s.sel == 0) ? int'(free_cnt_o) : (m_s.sel == 1) ? int'(alloc_ready_o) : int'(err_o);
`else
        m_act = (m_s.sel == 0) ? int'(free_cnt_o) : int'(alloc_ready_o);
`endif
        if (m_s.cyc != cyc || m_act != m_s.val) begin
          n_fail++;
          $display("FAIL %s: got %0d at cycle %0d, want %0d at cycle %0d",
                   m_s.name, m_act, cyc, m_s.val, m_s.cyc);
        end
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      while (exp_al_q.size() > 0) begin
        m_a = exp_al_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no allocation, want one", m_a.name);
      end
      while (exp_st_q.size() > 0) begin
        m_s = exp_st_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no sample, want %0d", m_s.name, m_s.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    do_reset();
    exp_state(0, 0, 64, "rst_cnt");
    exp_state(0, 1, 1, "rst_ready");

    // Full-width allocation straight out of reset
    alloc(4'b1111, 0, 1, 2, 3, "t1_preg");
    exp_state(1, 0, 60, "t1_cnt");
    step();
    clear_inputs();
    step();

    // Sparse request compacts onto the valid slots
    do_reset();
    alloc(4'b1010, 0, 0, 0, 1, "t2_sparse");
    exp_state(1, 0, 62, "t2_cnt");
    step();
    alloc(4'b1111, 2, 3, 4, 5, "t2_next");
    exp_state(1, 0, 58, "t2_cnt2");
    step();
    clear_inputs();
    step();

    // Drain to empty, stall, then refill through the wrapped tail
    do_reset();
    for (int k = 0; k < 16; k++) begin
      alloc(4'b1111, 4*k, 4*k+1, 4*k+2, 4*k+3, "t3_fill");
      if (k == 15) begin
        exp_state(1, 0, 0, "t3_empty_cnt");
        exp_state(1, 1, 0, "t3_empty_ready");
      end
      step();
    end
    alloc_valid_i  = 4'b1111;
    free_i         = 4'b0001;
    free_preg_i[0] = 6'd7;
    exp_state(1, 0, 1, "t3_cnt1");
    exp_state(1, 1, 0, "t3_ready_low");
    step();
    alloc_valid_i  = 4'b0000;
    free_i         = 4'b0111;
    free_preg_i[0] = 6'd8;
    free_preg_i[1] = 6'd9;
    free_preg_i[2] = 6'd10;
    exp_state(1, 0, 4, "t3_cnt4");
    exp_state(1, 1, 1, "t3_ready_back");
    step();
    free_i = 4'b0000;
    alloc(4'b1111, 7, 8, 9, 10, "t3_refill");
    exp_state(1, 0, 0, "t3_cnt0");
    step();
    clear_inputs();
    step();

    // Commit then restore, and restore with a same-cycle commit
    do_reset();
    alloc(4'b1111, 0, 1, 2, 3, "t4_a0");
    step();
    alloc(4'b1111, 4, 5, 6, 7, "t4_a1");
    exp_state(1, 0, 56, "t4_cnt56");
    step();
    alloc_valid_i = 4'b0000;
    commit_i      = 4'b0011;
    step();
    commit_i      = 4'b0000;
    restore_i     = 1'b1;
    alloc_valid_i = 4'b1111;
    exp_state(1, 0, 62, "t4_restore_cnt");
    step();
    restore_i = 1'b0;
    alloc(4'b1111, 2, 3, 4, 5, "t4_after_restore");
    exp_state(1, 0, 58, "t4_cnt58");
    step();
    alloc_valid_i = 4'b0000;
    commit_i      = 4'b0001;
    restore_i     = 1'b1;
    exp_state(1, 0, 61, "t4_restore_commit_cnt");
    step();
    commit_i  = 4'b0000;
    restore_i = 1'b0;
    alloc(4'b0001, 3, 0, 0, 0, "t4_head3");
    exp_state(1, 0, 60, "t4_cnt60");
    step();
    clear_inputs();
    step();

    // Simultaneous alloc and free, then consume up to the wrapped freed entries
    do_reset();
    alloc(4'b1111, 0, 1, 2, 3, "t5_a0");
    step();
    alloc(4'b1111, 4, 5, 6, 7, "t5_a1");
    free_i         = 4'b1111;
    free_preg_i[0] = 6'd3;
    free_preg_i[1] = 6'd2;
    free_preg_i[2] = 6'd1;
    free_preg_i[3] = 6'd0;
    exp_state(1, 0, 60, "t5_cnt_same");
    step();
    free_i = 4'b0000;
    for (int k = 2; k < 16; k++) begin
      alloc(4'b1111, 4*k, 4*k+1, 4*k+2, 4*k+3, "t5_walk");
      if (k == 15) exp_state(1, 0, 4, "t5_cnt4");
      step();
    end
    alloc(4'b1111, 3, 2, 1, 0, "t5_wrapped");
    exp_state(1, 0, 0, "t5_cnt0");
    step();
    clear_inputs();
    step();

`ifdef FREELIST_CHECK_EN
    do_reset();
    free_i         = 4'b0001;
    free_preg_i[0] = 6'd5;
    exp_state(1, 2, 1, "err_set");
    step();
    clear_inputs();
    step();
    step();
    exp_state(0, 2, 1, "err_sticky");
    step();
    do_reset();
    exp_state(0, 2, 0, "err_cleared");
    step();
`endif

    done = 1'b1;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
